// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display scan-out reads take the single RAM port during
// active video, and posted writer requests drain from a small queue during blanking.
module fb_port_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12,
    parameter int FB_SIZE  = 307200,
    parameter int RD_LAT   = 1,
    parameter int WQ_DEPTH = 8
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iDE,
    input  logic                          iHS,
    input  logic                          iVS,
    input  logic [ADDR_W-1:0]             iPos,
    input  logic                          iWrValid,
    input  logic [ADDR_W-1:0]             iWrAddr,
    input  logic [DATA_W-1:0]             iWrData,
    output logic                          oWrReady,
    input  logic                          iErrClr,
    output logic                          oMemEn,
    output logic                          oMemWe,
    output logic [ADDR_W-1:0]             oMemAddr,
    output logic [DATA_W-1:0]             oMemWrData,
    input  logic [DATA_W-1:0]             iMemRdData,
    output logic [DATA_W-1:0]             oPixData,
    output logic                          oPixDE,
    output logic                          oPixHS,
    output logic                          oPixVS,
    output logic [$clog2(WQ_DEPTH):0]     oWqLevel,
    output logic                          oAddrErr
);

    localparam int PTR_W  = $clog2(WQ_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int PIPE_L = RD_LAT + 2;
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(WQ_DEPTH);
    localparam logic [ADDR_W:0]   FB_LIMIT = (ADDR_W + 1)'(FB_SIZE);

    logic [ADDR_W-1:0] wqAddrMem [WQ_DEPTH];
    logic [DATA_W-1:0] wqDataMem [WQ_DEPTH];

    logic [PTR_W-1:0]  wrPtrReg;
    logic [PTR_W-1:0]  rdPtrReg;
    logic [LVL_W-1:0]  levelReg;
    logic              addrErrReg;
    logic              memEnReg;
    logic              memWeReg;
    logic [ADDR_W-1:0] memAddrReg;
    logic [DATA_W-1:0] memWrDataReg;
    logic [DATA_W-1:0] pixDataReg;
    logic [PIPE_L-1:0] deLine;
    logic [PIPE_L-1:0] hsLine;
    logic [PIPE_L-1:0] vsLine;

    logic inRange;
    logic doAccept;
    logic doPush;
    logic doPop;
    logic errSet;

    // Ready is forced low while reset is held so the writer cannot post into a dead queue.
    assign oWrReady = iRst && (levelReg != LVL_FULL);
    assign inRange  = {1'b0, iWrAddr} < FB_LIMIT;
    assign doAccept = iWrValid && oWrReady;
    assign doPush   = doAccept && inRange;
    assign errSet   = doAccept && !inRange;
    assign doPop    = !iDE && (levelReg != '0);

    always_ff @(posedge iClk) begin
        if (doPush) begin
            wqAddrMem[wrPtrReg] <= iWrAddr;
            wqDataMem[wrPtrReg] <= iWrData;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            wrPtrReg     <= '0;
            rdPtrReg     <= '0;
            levelReg     <= '0;
            addrErrReg   <= 1'b0;
            memEnReg     <= 1'b0;
            memWeReg     <= 1'b0;
            memAddrReg   <= '0;
            memWrDataReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + PTR_W'(1);
            if (doPop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   levelReg <= levelReg + LVL_W'(1);
                2'b01:   levelReg <= levelReg - LVL_W'(1);
                default: levelReg <= levelReg;
            endcase
            if (errSet)       addrErrReg <= 1'b1;
            else if (iErrClr) addrErrReg <= 1'b0;
            // Display read always wins; a pop only happens when the beam is idle.
            if (iDE) begin
                memEnReg   <= 1'b1;
                memWeReg   <= 1'b0;
                memAddrReg <= iPos;
            end else if (doPop) begin
                memEnReg     <= 1'b1;
                memWeReg     <= 1'b1;
                memAddrReg   <= wqAddrMem[rdPtrReg];
                memWrDataReg <= wqDataMem[rdPtrReg];
            end else begin
                memEnReg <= 1'b0;
                memWeReg <= 1'b0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            deLine[0] <= 1'b0;
            hsLine[0] <= 1'b1;
            vsLine[0] <= 1'b1;
        end else begin
            deLine[0] <= iDE;
            hsLine[0] <= iHS;
            vsLine[0] <= iVS;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < PIPE_L; gi++) begin : gDelay
            always_ff @(posedge iClk or negedge iRst) begin
                if (!iRst) begin
                    deLine[gi] <= 1'b0;
                    hsLine[gi] <= 1'b1;
                    vsLine[gi] <= 1'b1;
                end else begin
                    deLine[gi] <= deLine[gi-1];
                    hsLine[gi] <= hsLine[gi-1];
                    vsLine[gi] <= vsLine[gi-1];
                end
            end
        end
    endgenerate

    // RAM word for a read issued RD_LAT+1 edges ago is valid now; capture it alongside the final DE stage.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)                  pixDataReg <= '0;
        else if (deLine[PIPE_L-2])  pixDataReg <= iMemRdData;
        else                        pixDataReg <= '0;
    end

    assign oMemEn     = memEnReg;
    assign oMemWe     = memWeReg;
    assign oMemAddr   = memAddrReg;
    assign oMemWrData = memWrDataReg;
    assign oPixData   = pixDataReg;
    assign oPixDE     = deLine[PIPE_L-1];
    assign oPixHS     = hsLine[PIPE_L-1];
    assign oPixVS     = vsLine[PIPE_L-1];
    assign oWqLevel   = levelReg;
    assign oAddrErr   = addrErrReg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed table, corner sequences and
// randomized traffic checked against a queue-based model of the port rules.
module tb_fb_port_arbiter;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 12;
    localparam int FB_SIZE  = 307200;
    localparam int RD_LAT   = 1;
    localparam int WQ_DEPTH = 8;
    localparam int PIPE_L   = RD_LAT + 2;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iDE, iHS, iVS;
    logic [ADDR_W-1:0] iPos;
    logic              iWrValid;
    logic [ADDR_W-1:0] iWrAddr;
    logic [DATA_W-1:0] iWrData;
    logic              oWrReady;
    logic              iErrClr;
    logic              oMemEn, oMemWe;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemWrData;
    logic [DATA_W-1:0] iMemRdData = '0;
    logic [DATA_W-1:0] oPixData;
    logic              oPixDE, oPixHS, oPixVS;
    logic [$clog2(WQ_DEPTH):0] oWqLevel;
    logic              oAddrErr;

    int nChecks = 0;
    int nFail   = 0;

    fb_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_SIZE(FB_SIZE),
        .RD_LAT(RD_LAT), .WQ_DEPTH(WQ_DEPTH)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iDE(iDE), .iHS(iHS), .iVS(iVS), .iPos(iPos),
        .iWrValid(iWrValid), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrReady(oWrReady),
        .iErrClr(iErrClr), .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemWrData(oMemWrData), .iMemRdData(iMemRdData), .oPixData(oPixData),
        .oPixDE(oPixDE), .oPixHS(oPixHS), .oPixVS(oPixVS), .oWqLevel(oWqLevel),
        .oAddrErr(oAddrErr)
    );

    always #5 iClk = ~iClk;

    function automatic logic [DATA_W-1:0] ramWord(input logic [ADDR_W-1:0] a);
        return a[DATA_W-1:0];
    endfunction

    // One-cycle-latency RAM: word appears the cycle after a registered read command.
    always @(posedge iClk) begin
        if (oMemEn && !oMemWe) iMemRdData <= ramWord(oMemAddr);
    end

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wrEntry_t;
    typedef struct packed { logic de; logic hs; logic vs; logic [ADDR_W-1:0] pos; } beam_t;

    wrEntry_t          mq[$];
    beam_t             hist[$];
    logic              mEn, mWe, mErr;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mData;

    task automatic modelReset();
        mq.delete();
        hist.delete();
        for (int i = 0; i < PIPE_L; i++) hist.push_front('{de: 1'b0, hs: 1'b1, vs: 1'b1, pos: '0});
        mEn = 0; mWe = 0; mErr = 0; mAddr = '0; mData = '0;
    endtask

    task automatic modelEdge();
        int       lvl;
        bit       acc;
        wrEntry_t e;
        if (!iRst) begin
            modelReset();
            return;
        end
        lvl = mq.size();
        acc = iWrValid && (lvl != WQ_DEPTH);
        if (iDE) begin
            mEn = 1; mWe = 0; mAddr = iPos;
        end else if (lvl > 0) begin
            e = mq.pop_front();
            mEn = 1; mWe = 1; mAddr = e.addr; mData = e.data;
        end else begin
            mEn = 0; mWe = 0;
        end
        if (acc && int'(iWrAddr) < FB_SIZE) mq.push_back('{addr: iWrAddr, data: iWrData});
        if (acc && int'(iWrAddr) >= FB_SIZE) mErr = 1;
        else if (iErrClr)                    mErr = 0;
        hist.push_front('{de: iDE, hs: iHS, vs: iVS, pos: iPos});
        void'(hist.pop_back());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll();
        beam_t b;
        b = hist[PIPE_L-1];
        chk("memEn", 32'(oMemEn), 32'(mEn));
        chk("memWe", 32'(oMemWe), 32'(mWe));
        chk("memAddr", 32'(oMemAddr), 32'(mAddr));
        chk("memWrData", 32'(oMemWrData), 32'(mData));
        chk("wqLevel", 32'(oWqLevel), 32'(mq.size()));
        chk("wrReady", 32'(oWrReady), 32'(iRst && (mq.size() != WQ_DEPTH)));
        chk("addrErr", 32'(oAddrErr), 32'(mErr));
        chk("pixDE", 32'(oPixDE), 32'(b.de));
        chk("pixHS", 32'(oPixHS), 32'(b.hs));
        chk("pixVS", 32'(oPixVS), 32'(b.vs));
        chk("pixData", 32'(oPixData), b.de ? 32'(ramWord(b.pos)) : 32'd0);
    endtask

    task automatic step();
        @(posedge iClk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic setBeam(input logic de, input logic [ADDR_W-1:0] pos);
        iDE = de; iPos = pos;
    endtask

    task automatic setWr(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        iWrValid = v; iWrAddr = a; iWrData = d;
    endtask

    typedef struct {
        logic de, hs, vs;
        logic [ADDR_W-1:0] pos;
        logic eEn, eWe;
        logic [ADDR_W-1:0] eAddr;
        logic eDE;
        logic [DATA_W-1:0] eData;
        logic eHS, eVS;
    } vec_t;

    vec_t vt[7];

    initial begin
        // de hs vs pos | memEn memWe memAddr | pixDE pixData pixHS pixVS
        vt[0] = '{1, 1, 1, 100, 1, 0, 100, 0, 0,   1, 1};
        vt[1] = '{1, 0, 1, 101, 1, 0, 101, 0, 0,   1, 1};
        vt[2] = '{1, 0, 0, 102, 1, 0, 102, 1, 100, 1, 1};
        vt[3] = '{1, 1, 0, 103, 1, 0, 103, 1, 101, 0, 1};
        vt[4] = '{0, 1, 1, 0,   0, 0, 103, 1, 102, 0, 0};
        vt[5] = '{0, 1, 1, 0,   0, 0, 103, 1, 103, 1, 0};
        vt[6] = '{0, 1, 1, 0,   0, 0, 103, 0, 0,   1, 1};

        iRst = 0; iDE = 0; iHS = 1; iVS = 1; iPos = '0; iErrClr = 0;
        setWr(0, '0, '0);
        modelReset();

        // Reset held with DE toggling
        for (int i = 0; i < 4; i++) begin
            iDE = i[0];
            iWrValid = 1;
            step();
            chk("rst_ready_low", 32'(oWrReady), 32'd0);
        end
        iDE = 0; iWrValid = 0;
        iRst = 1;
        #1;
        chk("ready_after_release", 32'(oWrReady), 32'd1);

        // Directed table: display reads and sync alignment
        for (int r = 0; r < 7; r++) begin
            iDE = vt[r].de; iHS = vt[r].hs; iVS = vt[r].vs; iPos = vt[r].pos;
            step();
            chk($sformatf("tbl%0d_memEn", r), 32'(oMemEn), 32'(vt[r].eEn));
            chk($sformatf("tbl%0d_memWe", r), 32'(oMemWe), 32'(vt[r].eWe));
            chk($sformatf("tbl%0d_memAddr", r), 32'(oMemAddr), 32'(vt[r].eAddr));
            chk($sformatf("tbl%0d_pixDE", r), 32'(oPixDE), 32'(vt[r].eDE));
            chk($sformatf("tbl%0d_pixData", r), 32'(oPixData), 32'(vt[r].eData));
            chk($sformatf("tbl%0d_pixHS", r), 32'(oPixHS), 32'(vt[r].eHS));
            chk($sformatf("tbl%0d_pixVS", r), 32'(oPixVS), 32'(vt[r].eVS));
        end

        // Fill queue during active video, then drain in blanking
        for (int i = 0; i < 8; i++) begin
            setBeam(1, ADDR_W'(200 + i));
            setWr(1, ADDR_W'(10 + i), DATA_W'(12'h500 + i));
            step();
            chk("fill_noWe", 32'(oMemWe), 32'd0);
        end
        chk("fill_level", 32'(oWqLevel), 32'd8);
        chk("fill_ready", 32'(oWrReady), 32'd0);
        setWr(1, ADDR_W'(99), 12'h0AA);
        step();
        chk("full_hold_level", 32'(oWqLevel), 32'd8);
        setWr(0, '0, '0);
        setBeam(0, '0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_we", 32'(oMemWe), 32'd1);
            chk("drain_addr", 32'(oMemAddr), 32'(10 + i));
            chk("drain_data", 32'(oMemWrData), 32'(12'h500 + i));
        end
        step();
        chk("drain_level", 32'(oWqLevel), 32'd0);
        chk("drain_idle", 32'(oMemEn), 32'd0);

        // No bypass: pushed entry is not written on the same edge
        setWr(1, ADDR_W'(22), 12'h022);
        step();
        chk("nobypass_en", 32'(oMemEn), 32'd0);
        chk("nobypass_level", 32'(oWqLevel), 32'd1);
        // Simultaneous push and pop at level 1
        setWr(1, ADDR_W'(23), 12'h023);
        step();
        chk("pushpop_level", 32'(oWqLevel), 32'd1);
        chk("pushpop_addr", 32'(oMemAddr), 32'd22);
        setWr(0, '0, '0);
        step();
        chk("pushpop_next", 32'(oMemAddr), 32'd23);
        chk("pushpop_data", 32'(oMemWrData), 32'h023);

        // Address range and sticky error
        setBeam(1, ADDR_W'(5));
        setWr(1, ADDR_W'(FB_SIZE), 12'hBAD);
        step();
        chk("bad_err", 32'(oAddrErr), 32'd1);
        chk("bad_level", 32'(oWqLevel), 32'd0);
        setWr(1, ADDR_W'(FB_SIZE - 1), 12'h0EE);
        step();
        chk("last_ok_level", 32'(oWqLevel), 32'd1);
        setWr(1, ADDR_W'(FB_SIZE + 7), 12'hBAD);
        iErrClr = 1;
        step();
        chk("set_beats_clr", 32'(oAddrErr), 32'd1);
        setWr(0, '0, '0);
        step();
        chk("clr_alone", 32'(oAddrErr), 32'd0);
        iErrClr = 0;

        // Async reset mid-drain with 5 entries left
        for (int i = 0; i < 5; i++) begin
            setWr(1, ADDR_W'(40 + i), DATA_W'(i));
            step();
        end
        setWr(0, '0, '0);
        setBeam(0, '0);
        step();
        chk("middrain_level", 32'(oWqLevel), 32'd5);
        #2;
        iRst = 0;
        #1;
        modelReset();
        chk("async_memEn", 32'(oMemEn), 32'd0);
        chk("async_level", 32'(oWqLevel), 32'd0);
        checkAll();
        step();
        step();
        iRst = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale_we", 32'(oMemWe), 32'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) iDE = ~iDE;
            iHS = ($urandom_range(0, 9) != 0);
            iVS = ($urandom_range(0, 19) != 0);
            iPos = ADDR_W'($urandom_range(0, FB_SIZE - 1));
            iWrValid = $urandom_range(0, 1);
            iWrAddr = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(FB_SIZE, (1 << ADDR_W) - 1))
                                                   : ADDR_W'($urandom_range(0, FB_SIZE - 1));
            iWrData = DATA_W'($urandom);
            iErrClr = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
